// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: definitions shared by the Tomasulo reservation-station slice.
// Holds default operand/tag/opcode widths, the "no dependency" tag value,
// the per-entry state encoding and the CDB broadcast bundle.
package tomasulo_pkg;

  localparam int TAG_W_DEF  = 3;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF   = 3;

  // A producer tag of zero means the operand value is already present.
  localparam logic [TAG_W_DEF-1:0] NO_DEP = 3'd0;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_SENT  = 2'd3
  } rs_state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_t;

endpackage

// File: rtl/rs_bank_if.sv
// rs_bank_if: bundles the reservation-station bus signals.
//   issue_*   : issue request into the station (issue_ready back)
//   cdb_*     : common data bus snoop (tag + result)
//   disp_*    : valid/ready dispatch offer towards the functional unit
//   done_*    : completion confirmation from the functional unit
//   flush     : synchronous clear of every entry
//   busy_count, full : occupancy status
// Modport slave is the station side, master is the issue/FU/CDB side.
interface rs_bank_if
  import tomasulo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int STAMP_W = 10
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               issue_valid;
  logic               issue_ready;
  logic [OP_W-1:0]    issue_op;
  logic [DATA_W-1:0]  issue_vj;
  logic [DATA_W-1:0]  issue_vk;
  logic [TAG_W-1:0]   issue_qj;
  logic [TAG_W-1:0]   issue_qk;
  logic [STAMP_W-1:0] issue_stamp;
  logic               cdb_valid;
  logic [TAG_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]  cdb_data;
  logic               disp_valid;
  logic               disp_ready;
  logic [OP_W-1:0]    disp_op;
  logic [DATA_W-1:0]  disp_vj;
  logic [DATA_W-1:0]  disp_vk;
  logic [TAG_W-1:0]   disp_tag;
  logic [STAMP_W-1:0] disp_stamp;
  logic               done_valid;
  logic [TAG_W-1:0]   done_tag;
  logic               flush;
  logic [CNT_W-1:0]   busy_count;
  logic               full;

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_stamp,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready, done_valid, done_tag, flush,
    output issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_tag, disp_stamp,
    output busy_count, full
  );

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk, issue_stamp,
    output cdb_valid, cdb_tag, cdb_data, disp_ready, done_valid, done_tag, flush,
    input  issue_ready, disp_valid, disp_op, disp_vj, disp_vk, disp_tag, disp_stamp,
    input  busy_count, full
  );
endinterface

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot.
// Holds op/vj/vk/qj/qk/stamp and the FREE/WAIT/READY/SENT state machine,
// captures missing operands from the CDB and frees itself on a matching done.
// Ports: CLK, CLR (async reset), flush, alloc + alloc_* (already bypassed
// issue payload), cdb_*, disp_fire (this entry handshaken), done_*,
// and the registered fields as outputs.
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int STAMP_W   = 10,
  parameter int ENTRY_TAG = 1
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               flush,
  input  logic               alloc,
  input  logic [OP_W-1:0]    alloc_op,
  input  logic [DATA_W-1:0]  alloc_vj,
  input  logic [DATA_W-1:0]  alloc_vk,
  input  logic [TAG_W-1:0]   alloc_qj,
  input  logic [TAG_W-1:0]   alloc_qk,
  input  logic [STAMP_W-1:0] alloc_stamp,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_data,
  input  logic               disp_fire,
  input  logic               done_valid,
  input  logic [TAG_W-1:0]   done_tag,
  output rs_state_e          state,
  output logic [OP_W-1:0]    op,
  output logic [DATA_W-1:0]  vj,
  output logic [DATA_W-1:0]  vk,
  output logic [STAMP_W-1:0] stamp
);
  localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(ENTRY_TAG);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(NO_DEP);

  rs_state_e          state_r, state_s;
  logic [OP_W-1:0]    op_r, op_s;
  logic [DATA_W-1:0]  vj_r, vj_s, vk_r, vk_s;
  logic [TAG_W-1:0]   qj_r, qj_s, qk_r, qk_s;
  logic [STAMP_W-1:0] stamp_r, stamp_s;
  logic               cap_j_s, cap_k_s;

  assign cap_j_s = cdb_valid && (qj_r != NO_TAG) && (cdb_tag == qj_r);
  assign cap_k_s = cdb_valid && (qk_r != NO_TAG) && (cdb_tag == qk_r);

  // Next-state and next-field logic; flush overrides any same-cycle event.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    vj_s    = vj_r;
    vk_s    = vk_r;
    qj_s    = qj_r;
    qk_s    = qk_r;
    stamp_s = stamp_r;
    if (flush) begin
      state_s = RS_FREE;
      op_s    = '0;
      vj_s    = '0;
      vk_s    = '0;
      qj_s    = '0;
      qk_s    = '0;
      stamp_s = '0;
    end else begin
      case (state_r)
        RS_FREE: begin
          if (alloc) begin
            op_s    = alloc_op;
            vj_s    = alloc_vj;
            vk_s    = alloc_vk;
            qj_s    = alloc_qj;
            qk_s    = alloc_qk;
            stamp_s = alloc_stamp;
            if ((alloc_qj == NO_TAG) && (alloc_qk == NO_TAG)) state_s = RS_READY;
            else state_s = RS_WAIT;
          end else begin
            state_s = RS_FREE;
          end
        end
        RS_WAIT: begin
          // Both operands may be waiting on the same producer.
          if (cap_j_s) begin
            vj_s = cdb_data;
            qj_s = NO_TAG;
          end else begin
            vj_s = vj_r;
          end
          if (cap_k_s) begin
            vk_s = cdb_data;
            qk_s = NO_TAG;
          end else begin
            vk_s = vk_r;
          end
          if ((qj_s == NO_TAG) && (qk_s == NO_TAG)) state_s = RS_READY;
          else state_s = RS_WAIT;
        end
        RS_READY: begin
          if (disp_fire) state_s = RS_SENT;
          else state_s = RS_READY;
        end
        RS_SENT: begin
          if (done_valid && (done_tag == MY_TAG)) state_s = RS_FREE;
          else state_s = RS_SENT;
        end
        default: state_s = RS_FREE;
      endcase
    end
  end

  // Entry state and field registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r <= RS_FREE;
      op_r    <= '0;
      vj_r    <= '0;
      vk_r    <= '0;
      qj_r    <= '0;
      qk_r    <= '0;
      stamp_r <= '0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      vj_r    <= vj_s;
      vk_r    <= vk_s;
      qj_r    <= qj_s;
      qk_r    <= qk_s;
      stamp_r <= stamp_s;
    end
  end

  assign state = state_r;
  assign op    = op_r;
  assign vj    = vj_r;
  assign vk    = vk_r;
  assign stamp = stamp_r;
endmodule

// File: rtl/rs_bank.sv
// rs_bank: multi-entry reservation station.
// Allocates the lowest FREE entry on issue (with same-cycle CDB bypass),
// orders entries with an age matrix, offers the oldest READY entry on the
// dispatch handshake (frozen while stalled), and frees entries on done.
// Ports: CLK, CLR (async active-high reset), bus (rs_bank_if.slave).
module rs_bank
  import tomasulo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int OP_W     = OP_W_DEF,
  parameter int STAMP_W  = 10,
  parameter int BASE_TAG = 1
) (
  input logic     CLK,
  input logic     CLR,
  rs_bank_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(NO_DEP);

  if ((BASE_TAG < 1) || ((BASE_TAG + DEPTH - 1) >= (1 << TAG_W))) begin : g_bad_base_tag
    $error("rs_bank: BASE_TAG..BASE_TAG+DEPTH-1 must lie in 1..2^TAG_W-1");
  end

  rs_state_e          ent_state_s [DEPTH];
  logic [OP_W-1:0]    ent_op_s    [DEPTH];
  logic [DATA_W-1:0]  ent_vj_s    [DEPTH];
  logic [DATA_W-1:0]  ent_vk_s    [DEPTH];
  logic [STAMP_W-1:0] ent_stamp_s [DEPTH];
  logic [DEPTH-1:0]   age_r       [DEPTH];  // age_r[i][j]: entry i is older than j

  logic [DEPTH-1:0]  free_s, ready_s, done_hit_s, alloc_vec_s, disp_vec_s, oldest_s;
  logic [IDX_W-1:0]  alloc_idx_s, oldest_idx_s, sel_idx_s, lock_idx_r;
  logic              lock_r, any_ready_s, issue_fire_s, disp_fire_s;
  logic              byp_j_s, byp_k_s;
  logic [TAG_W-1:0]  eff_qj_s, eff_qk_s;
  logic [DATA_W-1:0] eff_vj_s, eff_vk_s;
  logic [CNT_W-1:0]  busy_s;

  // Issue-time bypass: a producer broadcasting now is not waited for.
  assign byp_j_s  = bus.cdb_valid && (bus.issue_qj != NO_TAG) && (bus.cdb_tag == bus.issue_qj);
  assign byp_k_s  = bus.cdb_valid && (bus.issue_qk != NO_TAG) && (bus.cdb_tag == bus.issue_qk);
  assign eff_qj_s = byp_j_s ? NO_TAG : bus.issue_qj;
  assign eff_qk_s = byp_k_s ? NO_TAG : bus.issue_qk;
  assign eff_vj_s = byp_j_s ? bus.cdb_data : bus.issue_vj;
  assign eff_vk_s = byp_k_s ? bus.cdb_data : bus.issue_vk;

  assign issue_fire_s = bus.issue_valid && (|free_s);
  assign any_ready_s  = |ready_s;
  assign sel_idx_s    = lock_r ? lock_idx_r : oldest_idx_s;
  assign disp_fire_s  = any_ready_s && bus.disp_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign free_s[g]      = (ent_state_s[g] == RS_FREE);
    assign ready_s[g]     = (ent_state_s[g] == RS_READY);
    assign done_hit_s[g]  = bus.done_valid && (ent_state_s[g] == RS_SENT) &&
                            (bus.done_tag == TAG_W'(BASE_TAG + g));
    assign alloc_vec_s[g] = issue_fire_s && (alloc_idx_s == IDX_W'(g));
    assign disp_vec_s[g]  = disp_fire_s && (sel_idx_s == IDX_W'(g));

    rs_entry #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .STAMP_W(STAMP_W),
      .ENTRY_TAG(BASE_TAG + g)
    ) u_entry (
      .CLK(CLK), .CLR(CLR), .flush(bus.flush),
      .alloc(alloc_vec_s[g]), .alloc_op(bus.issue_op),
      .alloc_vj(eff_vj_s), .alloc_vk(eff_vk_s),
      .alloc_qj(eff_qj_s), .alloc_qk(eff_qk_s), .alloc_stamp(bus.issue_stamp),
      .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
      .disp_fire(disp_vec_s[g]), .done_valid(bus.done_valid), .done_tag(bus.done_tag),
      .state(ent_state_s[g]), .op(ent_op_s[g]), .vj(ent_vj_s[g]), .vk(ent_vk_s[g]),
      .stamp(ent_stamp_s[g])
    );
  end

  // Lowest-index FREE entry (scan downwards so the lowest match wins).
  always_comb begin
    alloc_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_s[i]) alloc_idx_s = IDX_W'(i);
      else alloc_idx_s = alloc_idx_s;
    end
  end

  // Oldest READY entry: no other READY entry is older than it.
  always_comb begin
    oldest_s     = ready_s;
    oldest_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready_s[j] && age_r[j][i]) oldest_s[i] = 1'b0;
        else oldest_s[i] = oldest_s[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (oldest_s[i]) oldest_idx_s = IDX_W'(i);
      else oldest_idx_s = oldest_idx_s;
    end
  end

  // Age matrix: a newly allocated entry is younger than every occupied one;
  // a freed entry drops out of both its row and column.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) age_r[i] <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) age_r[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (done_hit_s[i] || done_hit_s[j]) age_r[i][j] <= 1'b0;
          else if (alloc_vec_s[j] && !free_s[i]) age_r[i][j] <= 1'b1;
          else if (alloc_vec_s[i]) age_r[i][j] <= 1'b0;
        end
      end
    end
  end

  // Dispatch lock: a stalled offer keeps its entry until accepted.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (bus.flush) begin
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (any_ready_s && !bus.disp_ready) begin
      lock_r     <= 1'b1;
      lock_idx_r <= sel_idx_s;
    end else begin
      lock_r     <= 1'b0;
    end
  end

  // Dispatch payload mux; all zero when nothing is offered.
  always_comb begin
    bus.disp_valid = any_ready_s;
    bus.disp_op    = '0;
    bus.disp_vj    = '0;
    bus.disp_vk    = '0;
    bus.disp_tag   = '0;
    bus.disp_stamp = '0;
    if (any_ready_s) begin
      bus.disp_op    = ent_op_s[sel_idx_s];
      bus.disp_vj    = ent_vj_s[sel_idx_s];
      bus.disp_vk    = ent_vk_s[sel_idx_s];
      bus.disp_tag   = TAG_W'(BASE_TAG) + TAG_W'(sel_idx_s);
      bus.disp_stamp = ent_stamp_s[sel_idx_s];
    end else begin
      bus.disp_op    = '0;
    end
  end

  // Occupancy count from registered entry state.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < DEPTH; i++) busy_s = busy_s + CNT_W'(!free_s[i]);
  end

  assign bus.busy_count  = busy_s;
  assign bus.full        = (busy_s == CNT_W'(DEPTH));
  assign bus.issue_ready = |free_s;
endmodule
